// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers signed operand pairs from a valid/ready producer
// in a small FIFO and issues at most one pair per cycle to the pipelined MAC.
// It honours a stall input, counts pairs within each dot-product vector and
// flags the last pair of every vector. There is no bypass: a pair pushed at one
// edge is issued at the following edge at the earliest.
module mac_operand_feeder #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int VEC_LEN = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       stall,
  output logic [DATA_W-1:0]          a_out,
  output logic [DATA_W-1:0]          b_out,
  output logic                       valid_out,
  output logic                       vec_done,
  output logic [$clog2(VEC_LEN)-1:0] issue_cnt,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(VEC_LEN);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Handshake and issue decisions use registered state only, so in_ready never
  // depends on stall or on a same-cycle pop: a full FIFO refuses the push.
  assign in_ready = (occupancy != OCC_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (occupancy != '0) && !stall;

  // Storage array written on every accepted push.
  // NOTE: the data array carries no reset; after reset the pointers and
  // occupancy say it is empty, so stale words are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // Pointers, occupancy, registered MAC-side outputs and vector counter.
  // NOTE: all state here uses non-blocking assignments so every decision sees
  // pre-edge values, which is what makes a same-edge push and pop consistent.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      issue_cnt <= '0;
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      vec_done  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        a_out     <= mem_a[rd_ptr];
        b_out     <= mem_b[rd_ptr];
        valid_out <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
        if (issue_cnt == CNT_LAST) begin
          issue_cnt <= '0;
          vec_done  <= 1'b1;
        end else begin
          issue_cnt <= issue_cnt + 1'b1;
          vec_done  <= 1'b0;
        end
      end else begin
        valid_out <= 1'b0;
        vec_done  <= 1'b0;
      end

      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder: directed scenarios against fixed
// expected values, then randomized traffic against a queue-based model.
module tb_mac_operand_feeder;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int VEC_LEN = 8;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [DATA_W-1:0]          in_a;
  logic [DATA_W-1:0]          in_b;
  logic                       in_valid;
  logic                       in_ready;
  logic                       stall;
  logic [DATA_W-1:0]          a_out;
  logic [DATA_W-1:0]          b_out;
  logic                       valid_out;
  logic                       vec_done;
  logic [$clog2(VEC_LEN)-1:0] issue_cnt;
  logic [$clog2(DEPTH):0]     occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffered pairs plus the last issued outputs.
  pair_t             q[$];
  logic [DATA_W-1:0] m_a;
  logic [DATA_W-1:0] m_b;
  logic              m_valid;
  logic              m_vd;
  int                m_cnt;

  mac_operand_feeder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .VEC_LEN(VEC_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .stall    (stall),
    .a_out    (a_out),
    .b_out    (b_out),
    .valid_out(valid_out),
    .vec_done (vec_done),
    .issue_cnt(issue_cnt),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge from the current inputs, then clock the DUT
  // and settle 1 time unit after the edge.
  task automatic step();
    bit    do_pop;
    bit    do_push;
    pair_t p;
    if (!reset) begin
      q.delete();
      m_a = '0; m_b = '0; m_valid = 1'b0; m_vd = 1'b0; m_cnt = 0;
    end else begin
      do_pop  = (q.size() != 0) && !stall;
      do_push = in_valid && (q.size() < DEPTH);
      if (do_pop) begin
        p       = q.pop_front();
        m_a     = p.a;
        m_b     = p.b;
        m_valid = 1'b1;
        m_vd    = (m_cnt == VEC_LEN - 1);
        m_cnt   = (m_cnt + 1) % VEC_LEN;
      end else begin
        m_valid = 1'b0;
        m_vd    = 1'b0;
      end
      if (do_push) begin
        p.a = in_a;
        p.b = in_b;
        q.push_back(p);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, '0, '0);
    stall = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (valid_out !== 1'b0 || a_out !== 8'd0 || b_out !== 8'd0 || vec_done !== 1'b0 ||
        in_ready !== 1'b1 || occupancy !== 3'd0 || issue_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b a=%0d b=%0d vd=%b rdy=%b occ=%0d cnt=%0d, exp all 0 except rdy=1",
               valid_out, a_out, b_out, vec_done, in_ready, occupancy, issue_cnt);
    end
  endtask

  task automatic test_two_pairs();
    do_reset();
    drive(1'b1, 8'd2, 8'd2);
    step();
    drive(1'b1, 8'd3, 8'd3);
    step();
    drive(1'b0, 8'd0, 8'd0);
    checks++;
    if (valid_out !== 1'b1 || a_out !== 8'd2 || b_out !== 8'd2) begin
      errors++;
      $display("FAIL first_issue: got v=%b a=%0d b=%0d, exp v=1 a=2 b=2", valid_out, a_out, b_out);
    end
    step();
    checks++;
    if (valid_out !== 1'b1 || a_out !== 8'd3 || b_out !== 8'd3) begin
      errors++;
      $display("FAIL second_issue: got v=%b a=%0d b=%0d, exp v=1 a=3 b=3", valid_out, a_out, b_out);
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || a_out !== 8'd3 || b_out !== 8'd3 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: got v=%b a=%0d b=%0d occ=%0d, exp v=0 a=3 b=3 occ=0",
               valid_out, a_out, b_out, occupancy);
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 8'(i));
      step();
    end
    checks++;
    if (occupancy !== 3'd4 || in_ready !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL fill: got occ=%0d rdy=%b v=%b, exp occ=4 rdy=0 v=0", occupancy, in_ready, valid_out);
    end
    drive(1'b1, 8'd5, 8'd5);
    step();
    checks++;
    if (occupancy !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_refuse: got occ=%0d rdy=%b, exp occ=4 rdy=0", occupancy, in_ready);
    end
    drive(1'b0, 8'd0, 8'd0);
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (valid_out !== 1'b1 || a_out !== 8'(i) || b_out !== 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d: got v=%b a=%0d b=%0d, exp v=1 a=%0d b=%0d", i, valid_out, a_out, b_out, i, i);
      end
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || in_ready !== 1'b1 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL drain_end: got v=%b rdy=%b occ=%0d, exp v=0 rdy=1 occ=0", valid_out, in_ready, occupancy);
    end
  endtask

  task automatic test_vector();
    do_reset();
    for (int j = 1; j <= 10; j++) begin
      if (j <= 9) drive(1'b1, 8'(j), 8'(j));
      else        drive(1'b0, 8'd0, 8'd0);
      step();
      if (j >= 2) begin
        checks++;
        if (valid_out !== 1'b1 || a_out !== 8'(j - 1) || vec_done !== ((j - 1) == 8) ||
            issue_cnt !== 3'((j - 1) % 8)) begin
          errors++;
          $display("FAIL vector_k%0d: got v=%b a=%0d vd=%b cnt=%0d, exp v=1 a=%0d vd=%b cnt=%0d",
                   j - 1, valid_out, a_out, vec_done, issue_cnt, j - 1, (j - 1) == 8, (j - 1) % 8);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    stall = 1'b1;
    drive(1'b1, 8'd20, 8'd80);
    step();
    drive(1'b1, 8'd21, 8'd79);
    step();
    stall = 1'b0;
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 8'(22 + n), 8'(78 - n));
      step();
      checks++;
      if (occupancy !== 3'd2 || valid_out !== 1'b1 || a_out !== 8'(20 + n) || b_out !== 8'(80 - n)) begin
        errors++;
        $display("FAIL b2b_%0d: got occ=%0d v=%b a=%0d b=%0d, exp occ=2 v=1 a=%0d b=%0d",
                 n, occupancy, valid_out, a_out, b_out, 20 + n, 80 - n);
      end
    end
    drive(1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(40 + i), 8'(i));
      step();
    end
    stall = 1'b0;
    for (int i = 3; i < 6; i++) begin
      drive(1'b1, 8'(40 + i), 8'(i));
      step();
    end
    checks++;
    if (occupancy !== 3'd3 || valid_out !== 1'b1 || issue_cnt !== 3'd3 || a_out !== 8'd42) begin
      errors++;
      $display("FAIL mid_setup: got occ=%0d v=%b cnt=%0d a=%0d, exp occ=3 v=1 cnt=3 a=42",
               occupancy, valid_out, issue_cnt, a_out);
    end
    reset = 1'b0;
    drive(1'b0, 8'd0, 8'd0);
    step();
    reset = 1'b1;
    checks++;
    if (occupancy !== 3'd0 || valid_out !== 1'b0 || issue_cnt !== 3'd0 || a_out !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got occ=%0d v=%b cnt=%0d a=%0d, exp all 0", occupancy, valid_out, issue_cnt, a_out);
    end
    drive(1'b1, 8'sd7, -8'sd3);
    step();
    drive(1'b0, 8'd0, 8'd0);
    step();
    checks++;
    if (valid_out !== 1'b1 || a_out !== 8'h07 || b_out !== 8'hFD || issue_cnt !== 3'd1 || vec_done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_pair: got v=%b a=%0d b=%0d cnt=%0d vd=%b, exp v=1 a=7 b=-3 cnt=1 vd=0",
               valid_out, $signed(a_out), $signed(b_out), issue_cnt, vec_done);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      stall = ($urandom_range(0, 9) < 3);
      drive($urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom));
      step();
      checks++;
      if (valid_out !== m_valid || vec_done !== m_vd || issue_cnt !== 3'(m_cnt) ||
          occupancy !== 3'(q.size()) || in_ready !== (q.size() != DEPTH) ||
          a_out !== m_a || b_out !== m_b) begin
        errors++;
        $display("FAIL random_%0d: got v=%b vd=%b cnt=%0d occ=%0d rdy=%b a=%0d b=%0d, exp v=%b vd=%b cnt=%0d occ=%0d rdy=%b a=%0d b=%0d",
                 i, valid_out, vec_done, issue_cnt, occupancy, in_ready, a_out, b_out,
                 m_valid, m_vd, m_cnt, q.size(), q.size() != DEPTH, m_a, m_b);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    drive(1'b0, '0, '0);
    test_reset();
    test_two_pairs();
    test_full_stall();
    test_vector();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Upstream stage for the pipelined signed MAC. Its a/b/valid outputs connect directly to the MAC's a, b and valid_in.
- Accepts operand pairs from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one pair per cycle to the MAC, honouring a stall input.
- Counts issued pairs and flags the last pair of each dot-product vector.

Parameters:
- DATA_W, 8, operand width in bits (signed two's complement).
- DEPTH, 4, FIFO entries. Power of 2, minimum 2.
- VEC_LEN, 8, pairs per vector. Minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in_a  input  DATA_W  producer operand a (signed).
- in_b  input  DATA_W  producer operand b (signed).
- in_valid  input  1  producer has a pair.
- in_ready  output  1  feeder can accept a pair.
- stall  input  1  inhibits issue to the MAC while high.
- a_out  output  DATA_W  to MAC a.
- b_out  output  DATA_W  to MAC b.
- valid_out  output  1  to MAC valid_in.
- vec_done  output  1  high with the last pair of a vector.
- issue_cnt  output  $clog2(VEC_LEN)  pairs issued so far in the current vector.
- occupancy  output  $clog2(DEPTH)+1  FIFO entries held.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Read/write pointers, occupancy and issue_cnt go to 0.
  - a_out, b_out, valid_out and vec_done go to 0.
  - Buffered contents are discarded.
  - Reset mid-stream follows the same rules. No pair is issued on the reset edge.
- Push:
  - in_ready = (occupancy != DEPTH). This is combinational from registered state only.
  - Push occurs when in_valid && in_ready at a clk edge. The pair is written at the write pointer, and the pointer wraps modulo DEPTH.
  - When full, pushes are refused even if a pop happens in the same cycle.
- Pop/issue:
  - A pop occurs at a clk edge when occupancy != 0 && stall == 0, evaluated on pre-edge state.
  - On a pop edge: a_out/b_out load the head pair, valid_out becomes 1, and the read pointer wraps modulo DEPTH.
  - On a non-pop edge: valid_out becomes 0 and vec_done becomes 0. a_out/b_out hold their previous values.
- Latency:
  - A pair pushed at edge k is issued at edge k+1 at the earliest.
  - There is no empty-FIFO bypass.
  - Throughput is one pair per cycle sustained.
- Simultaneous push and pop (not full): occupancy is unchanged and both pointers advance. Data order is strictly FIFO.
- Vector counting:
  - On each pop, issue_cnt increments.
  - If the pre-edge issue_cnt == VEC_LEN-1, issue_cnt wraps to 0 and vec_done is 1 on that same edge, together with valid_out.
  - vec_done is never high without valid_out.
- stall:
  - Asserting stall stops issue at the next edge. Pushes continue.
  - Deasserting stall resumes issue at the next edge.
- Data is passed through unmodified. No arithmetic is applied to the operands.

Test Plan:
- Reset hold, then release:
  - In the cycle after release: valid_out=0, a_out=0, b_out=0, vec_done=0, in_ready=1, occupancy=0, issue_cnt=0.
- Stall=0; push (2,2) at edge 2 and (3,3) at edge 3; in_valid=0 otherwise:
  - After edge 3: valid_out=1, a_out=2, b_out=2.
  - After edge 4: valid_out=1, a_out=3, b_out=3.
  - After edge 5: valid_out=0, a_out/b_out=3 held, occupancy=0.
- Stall=1; push (1,1),(2,2),(3,3),(4,4) in consecutive cycles, then offer (5,5):
  - occupancy=4, in_ready=0, and (5,5) is not accepted.
  - Drop stall: four consecutive valid_out cycles with a_out=1,2,3,4, then valid_out=0 and in_ready=1.
- VEC_LEN=8, stall=0; stream pairs (k,k) for k=1..9:
  - vec_done=1 only in the cycle where a_out=8; issue_cnt=0 after it.
  - The pair with a_out=9 has vec_done=0 and issue_cnt=1.
- Occupancy 2, stall=0, push asserted each cycle:
  - occupancy stays 2 across 5 cycles; outputs appear in push order.
- occupancy=3, valid_out=1, issue_cnt=3, then assert reset for one edge:
  - After that edge: occupancy=0, valid_out=0, issue_cnt=0, a_out=0.
  - The next pushed pair (7,-3) is issued as a_out=7, b_out=-3 with issue_cnt counting from 0.
